uart_tx: RTL

Transmit serializer of the UART. It sits between the register file's write-data path and the TX pin. Writes land in a small FIFO. Each entry is sent as one frame: start bit, LSB-first data, then stop bit(s). Frame format comes from the register-file configuration outputs (word_length, Num_stop_bits, oversample_by_3, enable_uart). Status goes back to the register file as fifo_status, data_valid and intr.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_if.sv | 29 ++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 138 +++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared types and constants.
// Used by the transmit path and the future receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int MIN_WORD_LEN = 5;
  localparam int OSR_BY3      = 3;

  function automatic logic [4:0] clamp_len(
    input logic [4:0] wl,
    input int         max_len
  );
    if (int'(wl) < MIN_WORD_LEN) return 5'(MIN_WORD_LEN);
    if (int'(wl) > max_len) return 5'(max_len);
    return wl;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Register-file side of the UART transmitter:
// write strobe/data in, status out.
interface uart_tx_if #(
  parameter int DATA_W = 16
) ();

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              fifo_status;
  logic              data_valid;
  logic              intr;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_status,
    input  data_valid,
    input  intr
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_status,
    output data_valid,
    output intr
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered full flag.
// Shared by the UART transmit and receive paths.
module uart_sync_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_nxt;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop) cnt_nxt = count + 1'b1;
    else if (do_pop && !do_push) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= cnt_nxt;
      full  <= (cnt_nxt == (AW+1)'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit serializer: FIFO-fed start/data/stop
// framing with per-frame latched configuration.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16,
  parameter int OSR_NORMAL = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick,
  input  logic       enable_uart,
  input  logic [4:0] word_length,
  input  logic       Num_stop_bits,
  input  logic       oversample_by_3,
  uart_tx_if.slave   bus,
  output logic       TX
);

  localparam int TW = $clog2(OSR_NORMAL);
  localparam int BW = $clog2(DATA_W);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] head;
  logic [TW-1:0]     tick_cnt;
  logic [TW-1:0]     osr_m1;
  logic [BW-1:0]     bit_cnt;
  logic [BW-1:0]     last_bit;
  logic              two_stop;
  logic              stop_cnt;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic              tick_end;
  logic              frame_end;
  logic              pop;
  logic              dv_q;
  logic              intr_q;

  uart_sync_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.wr_en),
    .pop   (pop),
    .din   (bus.wr_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.fifo_status = fifo_full;
  assign bus.data_valid  = dv_q;
  assign bus.intr        = intr_q;

  always_comb begin
    tick_end  = baud_tick && (tick_cnt == osr_m1);
    frame_end = (state == STOP) && tick_end
             && (stop_cnt == two_stop);
    pop = enable_uart && !fifo_empty
       && ((state == IDLE) || frame_end);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      TX       <= 1'b1;
      shift    <= '0;
      tick_cnt <= '0;
      osr_m1   <= '0;
      bit_cnt  <= '0;
      last_bit <= '0;
      two_stop <= 1'b0;
      stop_cnt <= 1'b0;
      dv_q     <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      intr_q <= frame_end;
      dv_q   <= (state != IDLE) || (fifo_count != '0);
      unique case (state)
        IDLE: TX <= 1'b1;
        START: begin
          if (tick_end) begin
            tick_cnt <= '0;
            state    <= DATA;
            TX       <= shift[0];
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_end) begin
            tick_cnt <= '0;
            if (bit_cnt == last_bit) begin
              state <= STOP;
              TX    <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[DATA_W-1:1]};
              TX      <= shift[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_end) begin
            tick_cnt <= '0;
            stop_cnt <= 1'b1;
            if (frame_end) state <= IDLE;
          end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
      endcase
      // A pop overrides the state update: frames run back to back.
      if (pop) begin
        shift    <= head;
        last_bit <= BW'(clamp_len(word_length, DATA_W) - 5'd1);
        osr_m1   <= oversample_by_3 ? TW'(OSR_BY3 - 1)
                                    : TW'(OSR_NORMAL - 1);
        two_stop <= Num_stop_bits;
        tick_cnt <= '0;
        bit_cnt  <= '0;
        stop_cnt <= 1'b0;
        state    <= START;
        TX       <= 1'b0;
      end
    end
  end

endmodule
